handshake_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one handshake CDC synchronizer (source side) among NUM_REQ requesters.

---
 rtl/handshake_rr_arbiter_if.sv | 28 ++
 rtl/handshake_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_handshake_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/handshake_rr_arbiter_if.sv
// Bus between the round-robin arbiter, its requesters and the source side of a handshake synchronizer.
// The master modport is the arbiter's view; slave is the requester/synchronizer environment.
interface handshake_rr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          hs_valid;
  logic [DATA_WIDTH-1:0]         hs_data;
  logic                          hs_busy;
  logic [GRANT_W-1:0]            grant_id;
  logic                          active;
  logic                          err;

  modport master (
    input  req, req_data, hs_busy,
    output ack, hs_valid, hs_data, grant_id, active, err
  );

  modport slave (
    output req, req_data, hs_busy,
    input  ack, hs_valid, hs_data, grant_id, active, err
  );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter feeding one handshake synchronizer: one transfer in flight at a time,
// waits out the synchronizer busy window, and flags a transfer that is never acknowledged.
module handshake_rr_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input logic                     clk,
  input logic                     rst,
  handshake_rr_arbiter_if.master  bus
);
  localparam int unsigned GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W   = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [GRANT_W-1:0]    ptr, ptr_nxt, win;
  logic                  win_ok;
  logic [DATA_WIDTH-1:0] slot [NUM_REQ];

  logic [NUM_REQ-1:0]    ack_q, ack_nxt;
  logic                  valid_q, valid_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic [GRANT_W-1:0]    grant_q, grant_nxt;
  logic                  active_q, active_nxt;
  logic                  err_q, err_nxt;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First requester at or above ptr, wrapping around
  always_comb begin
    int unsigned idx;
    idx    = 0;
    win    = '0;
    win_ok = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_ok && bus.req[GRANT_W'(idx)]) begin
        win    = GRANT_W'(idx);
        win_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The timeout exit is taken one cycle after cnt reaches BUSY_TIMEOUT-1,
  // so err lands BUSY_TIMEOUT+2 cycles after the issue pulse.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:      if (win_ok && !bus.hs_busy) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt = WAIT_BUSY;
        cnt_nxt   = '0;
      end
      WAIT_BUSY: begin
        if (bus.hs_busy)                            state_nxt = WAIT_IDLE;
        else if (cnt == CNT_W'(BUSY_TIMEOUT))       state_nxt = IDLE;
        else                                        cnt_nxt   = cnt + CNT_W'(1);
      end
      WAIT_IDLE: if (!bus.hs_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_nxt    = '0;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    data_nxt   = data_q;
    grant_nxt  = grant_q;
    ptr_nxt    = ptr;
    active_nxt = (state_nxt != IDLE);
    if (state == IDLE && state_nxt == ISSUE) begin
      ack_nxt[win] = 1'b1;
      valid_nxt    = 1'b1;
      data_nxt     = slot[win];
      grant_nxt    = win;
      ptr_nxt      = (32'(win) == NUM_REQ - 1) ? '0 : win + GRANT_W'(1);
    end
    if (state == WAIT_BUSY && state_nxt == IDLE) err_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      ptr      <= '0;
      ack_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      grant_q  <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      ptr      <= ptr_nxt;
      ack_q    <= ack_nxt;
      valid_q  <= valid_nxt;
      data_q   <= data_nxt;
      grant_q  <= grant_nxt;
      active_q <= active_nxt;
      err_q    <= err_nxt;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.hs_valid = valid_q;
  assign bus.hs_data  = data_q;
  assign bus.grant_id = grant_q;
  assign bus.active   = active_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Bench for handshake_rr_arbiter: vector table, corner-case sequences and random rounds
// against a queue-based round-robin model, with a simple synchronizer busy model.
module tb_handshake_rr_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned T  = 16;

  logic clk;
  logic rst;
  logic force_busy, model_busy, bm_pending;
  int   bm_mode, bm_lat, bm_len;
  int   n_cmp, n_bad, err_seen;
  int   order [$];

  handshake_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  handshake_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.hs_busy = force_busy | model_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          exp_id;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Synchronizer stand-in: busy rises bm_lat cycles after an issue and stays for bm_len cycles
  initial begin
    model_busy = 1'b0;
    bm_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.hs_valid && bm_mode != 0) begin
        bm_pending = 1'b1;
        repeat (bm_lat) @(negedge clk);
        model_busy = 1'b1;
        repeat (bm_len) @(negedge clk);
        model_busy = 1'b0;
        bm_pending = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.err) err_seen++;
  end

  function automatic void mdl_reset();
    order = {0, 1, 2, 3};
  endfunction

  function automatic int mdl_pick(input logic [3:0] r);
    foreach (order[i]) if (r[order[i]]) return order[i];
    return -1;
  endfunction

  function automatic void mdl_advance(input int w);
    int nxt;
    int t;
    nxt = (w + 1) % N;
    while (order[0] != nxt) begin
      t = order.pop_front();
      order.push_back(t);
    end
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.active || bus.hs_busy || bm_pending) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) bound_fail("idle_wait");
  endtask

  // One request round: idle, drive, expect the issue pulse exactly one cycle later
  task automatic run(input logic [3:0] r, input logic [31:0] d, input int fixed_id,
                     input logic [7:0] fixed_d, input string tag);
    int         w;
    logic [7:0] ed;
    wait_idle();
    w  = (fixed_id >= 0) ? fixed_id : mdl_pick(r);
    ed = (fixed_id >= 0) ? fixed_d : d[8*w +: 8];
    @(negedge clk);
    bus.req      = r;
    bus.req_data = d;
    @(negedge clk);
    chk({tag, "_valid"},  32'(bus.hs_valid), 32'd1);
    chk({tag, "_ack"},    32'(bus.ack), 32'(1 << w));
    chk({tag, "_id"},     32'(bus.grant_id), 32'(w));
    chk({tag, "_data"},   32'(bus.hs_data), 32'(ed));
    chk({tag, "_active"}, 32'(bus.active), 32'd1);
    bus.req = '0;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'({bus.hs_valid, bus.ack}), 32'd0);
    mdl_advance(w);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  r;
    int          n;
    logic        seen;

    n_cmp = 0; n_bad = 0; err_seen = 0;
    rst = 1'b1; force_busy = 1'b0;
    bm_mode = 1; bm_lat = 1; bm_len = 3;
    bus.req = '0; bus.req_data = '0;
    mdl_reset();

    tbl[0]  = '{4'b0100, 32'h00A5_0000, 2, 8'hA5};
    tbl[1]  = '{4'b1111, 32'h1312_1110, 3, 8'h13};
    tbl[2]  = '{4'b1111, 32'h1312_1110, 0, 8'h10};
    tbl[3]  = '{4'b1111, 32'h1312_1110, 1, 8'h11};
    tbl[4]  = '{4'b1111, 32'h1312_1110, 2, 8'h12};
    tbl[5]  = '{4'b0001, 32'h1312_1110, 0, 8'h10};
    tbl[6]  = '{4'b1001, 32'h1312_1110, 3, 8'h13};
    tbl[7]  = '{4'b1001, 32'h1312_1110, 0, 8'h10};
    tbl[8]  = '{4'b0110, 32'h1312_1110, 1, 8'h11};
    tbl[9]  = '{4'b0110, 32'h1312_1110, 2, 8'h12};
    tbl[10] = '{4'b1000, 32'h1312_1110, 3, 8'h13};
    tbl[11] = '{4'b1001, 32'h1312_1110, 0, 8'h10};
    tbl[12] = '{4'b1001, 32'h1312_1110, 3, 8'h13};

    #12;
    chk("rst_ack",    32'(bus.ack), 32'd0);
    chk("rst_valid",  32'(bus.hs_valid), 32'd0);
    chk("rst_data",   32'(bus.hs_data), 32'd0);
    chk("rst_grant",  32'(bus.grant_id), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    chk("rst_err",    32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run(tbl[i].req, tbl[i].data, tbl[i].exp_id, tbl[i].exp_data, "tbl");
    wait_idle();
    chk("data_hold", 32'(bus.hs_data), 32'h13);

    for (int i = 0; i < 40; i++) run(4'b1111, 32'h1312_1110, -1, 8'h00, "fair");

    // Busy held high in IDLE blocks the grant; release issues promptly
    wait_idle();
    force_busy = 1'b1;
    @(negedge clk);
    bus.req = 4'b0001; bus.req_data = 32'h0000_0042;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.hs_valid || bus.active) seen = 1'b1;
    end
    chk("busy_hold", 32'(seen), 32'd0);
    force_busy = 1'b0;
    n = 0;
    while (!bus.hs_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rel_lat", 32'(n >= 1 && n <= 2), 32'd1);
    chk("busy_rel_ack", 32'(bus.ack), 32'(1 << mdl_pick(4'b0001)));
    chk("busy_rel_data", 32'(bus.hs_data), 32'h42);
    bus.req = '0;
    mdl_advance(0);

    // Synchronizer never goes busy: err pulse BUSY_TIMEOUT+2 cycles after the issue
    wait_idle();
    bm_mode = 0;
    @(negedge clk);
    bus.req = 4'b0010; bus.req_data = 32'h0000_7700;
    @(negedge clk);
    chk("to_valid", 32'(bus.hs_valid), 32'd1);
    bus.req = '0;
    mdl_advance(1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = bus.err;
    end
    if (!seen) bound_fail("to_err_wait");
    chk("to_err_delay", 32'(n), 32'(T + 2));
    chk("to_active", 32'(bus.active), 32'd0);
    @(negedge clk);
    chk("to_err_pulse", 32'(bus.err), 32'd0);
    bm_mode = 1;
    run(4'b0001, 32'h0000_0055, -1, 8'h00, "to_next");

    // Async reset while waiting for busy to drop
    bm_lat = 1; bm_len = 12;
    run(4'b0100, 32'h00C3_0000, -1, 8'h00, "ar_pre");
    n = 0;
    while (!(bus.hs_busy && bus.active) && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) bound_fail("ar_busy_wait");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_pulses", 32'({bus.hs_valid, bus.ack, bus.err}), 32'd0);
    chk("ar_data",   32'(bus.hs_data), 32'd0);
    chk("ar_grant",  32'(bus.grant_id), 32'd0);
    chk("ar_active", 32'(bus.active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    bm_len = 3;
    run(4'b1001, 32'h7700_005A, 0, 8'h5A, "ar_first");
    run(4'b1001, 32'h7700_005A, 3, 8'h77, "ar_second");

    // Random rounds against the model
    for (int i = 0; i < 150; i++) begin
      wait_idle();
      bm_lat = $urandom_range(1, 3);
      bm_len = $urandom_range(1, 6);
      r = 4'($urandom);
      d = $urandom;
      if (r == 4'b0000) begin
        @(negedge clk);
        bus.req = r;
        seen = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (bus.hs_valid || bus.active) seen = 1'b1;
        end
        chk("rnd_noreq", 32'(seen), 32'd0);
      end else begin
        run(r, d, -1, 8'h00, "rnd");
      end
    end

    wait_idle();
    chk("err_total", 32'(err_seen), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end
endmodule
